// File: rtl/nibble_serializer.sv
// Serializes a 4-bit word, LSB first, onto one registered line feeding a
// downstream SIPO register; flags the cycle the downstream holds the whole word.
module nibble_serializer #(
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [3:0] i_DATA,
    input  logic       i_VALID,
    output logic       o_READY,
    output logic       o_D,
    output logic       o_BUSY,
    output logic       o_WORD_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic       HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] hold_r;
    logic [3:0] hold_nxt_s;
    logic [1:0] idx_r;
    logic [1:0] idx_nxt_s;
    logic [3:0] gcnt_r;
    logic [3:0] gcnt_nxt_s;
    logic       d_nxt_s;
    logic       done_nxt_s;
    logic       last_bit_s;
    logic       ready_s;
    logic       accept_s;

    // Ready decode. The final slot of a word (last bit with no gap, else the
    // final gap cycle) also accepts, so the idle run on o_D is exactly GAP_CYCLES.
    always_comb begin
        last_bit_s = 1'b0;
        ready_s    = 1'b0;
        if ((state_r == ST_SHIFT) && (idx_r == 2'd0)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
        if (i_RST) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:  ready_s = 1'b1;
                ST_SHIFT: ready_s = last_bit_s & ~HAS_GAP;
                ST_GAP:   ready_s = (gcnt_r == 4'd0);
                default:  ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s    = i_VALID & ready_s;
    assign o_READY     = ready_s;
    assign o_BUSY      = (state_r != ST_IDLE);

    // Next-state and next-output decode; an accept overrides whatever the state would do.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        idx_nxt_s   = idx_r;
        gcnt_nxt_s  = gcnt_r;
        d_nxt_s     = o_D;
        done_nxt_s  = 1'b0;
        if (accept_s) begin
            state_nxt_s = ST_SHIFT;
            hold_nxt_s  = i_DATA;
            idx_nxt_s   = 2'd1;
            d_nxt_s     = i_DATA[0];
            done_nxt_s  = last_bit_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    d_nxt_s = IDLE_BIT;
                end
                ST_SHIFT: begin
                    if (last_bit_s) begin
                        done_nxt_s = 1'b1;
                        d_nxt_s    = IDLE_BIT;
                        idx_nxt_s  = 2'd0;
                        if (HAS_GAP) begin
                            state_nxt_s = ST_GAP;
                            gcnt_nxt_s  = GAP_LOAD;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        d_nxt_s   = hold_r[idx_r];
                        idx_nxt_s = idx_r + 2'd1;
                    end
                end
                ST_GAP: begin
                    d_nxt_s = IDLE_BIT;
                    if (gcnt_r == 4'd0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        gcnt_nxt_s = gcnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    d_nxt_s     = IDLE_BIT;
                end
            endcase
        end
    end

    // State and registered outputs; reset discards any word in flight.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r     <= ST_IDLE;
            hold_r      <= 4'd0;
            idx_r       <= 2'd0;
            gcnt_r      <= 4'd0;
            o_D         <= IDLE_BIT;
            o_WORD_DONE <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_r      <= hold_nxt_s;
            idx_r       <= idx_nxt_s;
            gcnt_r      <= gcnt_nxt_s;
            o_D         <= d_nxt_s;
            o_WORD_DONE <= done_nxt_s;
        end
    end

endmodule
